// File: rtl/mac_array_pkg.sv
// mac_array_pkg: FSM encoding and width helpers shared by the MAC array.
// Saturating accumulation is enabled by defining MAC_ARRAY_SAT_EN.
package mac_array_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_EXEC = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int acc_width(input int data_w, input int depth);
    return 2 * data_w + $clog2(depth);
  endfunction

endpackage

// File: rtl/mac_lane.sv
// mac_lane: one row of the MAC array; A buffer, product register, accumulator.
// With MAC_ARRAY_SAT_EN the accumulator clamps and raises a sticky overflow.
module mac_lane
  import mac_array_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ACC_W  = acc_width(DATA_W, DEPTH),
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clr,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [PTR_W-1:0]  i_wr_ptr,
  input  logic [PTR_W-1:0]  i_rd_ptr,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [ACC_W-1:0]  o_acc
`ifdef MAC_ARRAY_SAT_EN
  ,
  output logic              o_ovf
`endif
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [ACC_W-1:0] ACC_MAX = '1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_prod;
  logic              r_pv;
  logic [ACC_W-1:0]  r_acc;

  logic [PW-1:0] w_pa;
  logic [PW-1:0] w_pb;
  logic [SW-1:0] w_sum;

  assign w_pa  = {{DATA_W{1'b0}}, r_mem[i_rd_ptr]};
  assign w_pb  = {{DATA_W{1'b0}}, i_b};
  assign w_sum = SW'(r_acc) + SW'(r_prod);

  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_ptr] <= i_a;
  end

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_prod <= '0;
      r_pv   <= 1'b0;
    end else begin
      r_pv <= i_rd_en;
      if (i_rd_en) r_prod <= w_pa * w_pb;
    end
  end

`ifdef MAC_ARRAY_SAT_EN
  logic r_ovf;

  // Unsigned sums only grow, so a clamped lane stays clamped.
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_acc <= '0;
      r_ovf <= 1'b0;
    end else if (r_pv) begin
      if (w_sum > SW'(ACC_MAX)) begin
        r_acc <= ACC_MAX;
        r_ovf <= 1'b1;
      end else begin
        r_acc <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign o_ovf = r_ovf;
`else
  always_ff @(posedge clk) begin
    if (rst || i_clr) r_acc <= '0;
    else if (r_pv)    r_acc <= w_sum[ACC_W-1:0];
  end
`endif

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_array_engine.sv
// mac_array_engine: LANES parallel dot products against a shared B vector.
// Define MAC_ARRAY_SAT_EN for saturating lanes and the sat_flag port.
module mac_array_engine
  import mac_array_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int LANES  = 2,
  parameter int ACC_W  = acc_width(DATA_W, DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*DATA_W-1:0]  in_a,
  input  logic [DATA_W-1:0]        in_b,
  output logic [LANES*ACC_W-1:0]   result,
  output logic                     done,
  output logic                     busy,
  output logic [STATE_W-1:0]       state
`ifdef MAC_ARRAY_SAT_EN
  ,
  output logic                     sat_flag
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(DEPTH);

  state_e            r_state;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_ecnt;
  logic [DATA_W-1:0] r_b_mem [DEPTH];

  logic w_clr;
  logic w_wr;
  logic w_rd;

  assign w_clr = start &&
                 (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_wr  = in_valid && (r_state == ST_FILL);
  assign w_rd  = (r_state == ST_EXEC) && (r_ecnt != CNT_END);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ecnt   <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state  <= ST_FILL;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_ecnt   <= '0;
          end
        end
        ST_FILL: begin
          if (in_valid) begin
            if (r_wr_ptr == PTR_LAST) begin
              r_state  <= ST_EXEC;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_ecnt   <= '0;
            end else begin
              r_wr_ptr <= r_wr_ptr + 1'b1;
            end
          end
        end
        ST_EXEC: begin
          // Extra cycle after the last issue drains the product register.
          if (w_rd) begin
            r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0
                                               : r_rd_ptr + 1'b1;
            r_ecnt   <= r_ecnt + 1'b1;
          end else begin
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_b_mem[r_wr_ptr] <= in_b;
  end

`ifdef MAC_ARRAY_SAT_EN
  logic [LANES-1:0] w_ovf;
  assign sat_flag = |w_ovf;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    mac_lane #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ACC_W  (ACC_W),
      .PTR_W  (PTR_W)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .i_clr    (w_clr),
      .i_wr_en  (w_wr),
      .i_rd_en  (w_rd),
      .i_wr_ptr (r_wr_ptr),
      .i_rd_ptr (r_rd_ptr),
      .i_a      (in_a[g*DATA_W +: DATA_W]),
      .i_b      (r_b_mem[r_rd_ptr]),
      .o_acc    (result[g*ACC_W +: ACC_W])
`ifdef MAC_ARRAY_SAT_EN
      ,
      .o_ovf    (w_ovf[g])
`endif
    );
  end

  assign in_ready = (r_state == ST_FILL);
  assign busy     = (r_state == ST_FILL) || (r_state == ST_EXEC);
  assign done     = (r_state == ST_DONE);
  assign state    = r_state;

endmodule

// File: tb/tb_mac_array_engine.sv
// tb_mac_array_engine: directed checks of the MAC array engine.
// Covers default widths and a narrow ACC_W=16 instance (MAC_ARRAY_SAT_EN aware).
module tb_mac_array_engine;

  int n_vec = 0;
  int n_err = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_a = '0;
  logic [7:0]  in_b = '0;

  logic        in_ready;
  logic [37:0] result;
  logic        done;
  logic        busy;
  logic [1:0]  state;

  logic        rdy16;
  logic [31:0] r16;
  logic        done16;
  logic        busy16;
  logic [1:0]  st16;
`ifdef MAC_ARRAY_SAT_EN
  logic        sat0;
  logic        sat16;
`endif

  mac_array_engine u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .state    (state)
`ifdef MAC_ARRAY_SAT_EN
    ,
    .sat_flag (sat0)
`endif
  );

  mac_array_engine #(.ACC_W(16)) u_dut16 (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (rdy16),
    .in_a     (in_a),
    .in_b     (in_b),
    .result   (r16),
    .done     (done16),
    .busy     (busy16),
    .state    (st16)
`ifdef MAC_ARRAY_SAT_EN
    ,
    .sat_flag (sat16)
`endif
  );

  logic [7:0] va0 [8];
  logic [7:0] va1 [8];
  logic [7:0] vb  [8];

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(input bit gaps, output int acc_n,
                      output int rdy_low);
    int guard = 0;
    bit ph = 1'b0;
    acc_n = 0;
    rdy_low = 0;
    while (acc_n < 8 && guard < 100) begin
      in_valid = gaps ? ph : 1'b1;
      ph = ~ph;
      in_a = {va1[acc_n], va0[acc_n]};
      in_b = vb[acc_n];
      if (!in_ready) rdy_low++;
      if (in_valid && in_ready) acc_n++;
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic load_basic();
    for (int i = 0; i < 8; i++) begin
      va0[i] = 8'(5 * i);
      va1[i] = 8'd1;
      vb[i]  = 8'(10 * i);
    end
  endtask

  task automatic load_const(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      va0[i] = v;
      va1[i] = v;
      vb[i]  = v;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if (state !== 2'd0) begin
      n_err++;
      $display("FAIL reset_state got %0d exp 0", state);
    end
    n_vec++;
    if (result !== 38'd0) begin
      n_err++;
      $display("FAIL reset_result got %0h exp 0", result);
    end
    n_vec++;
    if ({done, busy, in_ready} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags got %b exp 000",
               {done, busy, in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL idle_ready got %b exp 0", in_ready);
    end
  endtask

  task automatic test_basic();
    int an, rl, cyc;
    load_basic();
    pulse_start();
    n_vec++;
    if ({state, busy, in_ready} !== 4'b0111) begin
      n_err++;
      $display("FAIL fill_entry got %b exp 0111",
               {state, busy, in_ready});
    end
    feed(1'b0, an, rl);
    n_vec++;
    if (an !== 8) begin
      n_err++;
      $display("FAIL basic_beats got %0d exp 8", an);
    end
    n_vec++;
    if ({state, in_ready} !== 3'b100) begin
      n_err++;
      $display("FAIL exec_entry got %b exp 100", {state, in_ready});
    end
    wait_done(cyc);
    n_vec++;
    if (cyc !== 9) begin
      n_err++;
      $display("FAIL basic_latency got %0d exp 9", cyc);
    end
    repeat (4) @(negedge clk);
    n_vec++;
    if (result[18:0] !== 19'd7000) begin
      n_err++;
      $display("FAIL basic_lane0 got %0d exp 7000", result[18:0]);
    end
    n_vec++;
    if (result[37:19] !== 19'd280) begin
      n_err++;
      $display("FAIL basic_lane1 got %0d exp 280", result[37:19]);
    end
    n_vec++;
    if ({state, done, busy} !== 4'b1110) begin
      n_err++;
      $display("FAIL basic_done got %b exp 1110",
               {state, done, busy});
    end
`ifdef MAC_ARRAY_SAT_EN
    n_vec++;
    if (sat0 !== 1'b0) begin
      n_err++;
      $display("FAIL basic_sat got %b exp 0", sat0);
    end
`endif
  endtask

  task automatic test_gaps();
    int an, rl, cyc;
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL done_ready got %b exp 0", in_ready);
    end
    load_basic();
    pulse_start();
    feed(1'b1, an, rl);
    n_vec++;
    if (rl !== 0) begin
      n_err++;
      $display("FAIL gap_ready_low got %0d exp 0", rl);
    end
    n_vec++;
    if ({an, state} !== {32'd8, 2'd2}) begin
      n_err++;
      $display("FAIL gap_beats got %0d/%0d exp 8/2", an, state);
    end
    in_valid = 1'b1;
    in_a = 16'hffff;
    in_b = 8'hff;
    wait_done(cyc);
    in_valid = 1'b0;
    n_vec++;
    if (result !== {19'd280, 19'd7000}) begin
      n_err++;
      $display("FAIL gap_result got %0d/%0d exp 280/7000",
               result[37:19], result[18:0]);
    end
  endtask

  task automatic test_restart();
    int an, rl, cyc;
    load_const(8'd1);
    pulse_start();
    n_vec++;
    if ({done, state} !== 3'b001) begin
      n_err++;
      $display("FAIL restart_drop got %b exp 001", {done, state});
    end
    n_vec++;
    if (result !== 38'd0) begin
      n_err++;
      $display("FAIL restart_clr got %0h exp 0", result);
    end
    feed(1'b0, an, rl);
    wait_done(cyc);
    n_vec++;
    if (result !== {19'd8, 19'd8}) begin
      n_err++;
      $display("FAIL restart_result got %0d/%0d exp 8/8",
               result[37:19], result[18:0]);
    end
  endtask

  task automatic test_reset_mid_exec();
    int an, rl, cyc;
    load_basic();
    pulse_start();
    feed(1'b0, an, rl);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({state, done, busy} !== 4'b0000) begin
      n_err++;
      $display("FAIL midrst_flags got %b exp 0000",
               {state, done, busy});
    end
    n_vec++;
    if (result !== 38'd0) begin
      n_err++;
      $display("FAIL midrst_result got %0h exp 0", result);
    end
    load_basic();
    pulse_start();
    feed(1'b0, an, rl);
    wait_done(cyc);
    n_vec++;
    if (result !== {19'd280, 19'd7000} || cyc !== 9) begin
      n_err++;
      $display("FAIL midrst_rerun got %0d/%0d/%0d exp 280/7000/9",
               result[37:19], result[18:0], cyc);
    end
  endtask

  task automatic test_start_with_valid();
    int an, rl, cyc;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    start = 1'b1;
    in_valid = 1'b1;
    in_a = 16'hffff;
    in_b = 8'hff;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b0;
    n_vec++;
    if ({state, in_ready} !== 3'b011) begin
      n_err++;
      $display("FAIL sv_fill got %b exp 011", {state, in_ready});
    end
    load_const(8'd1);
    feed(1'b0, an, rl);
    n_vec++;
    if (state !== 2'd2) begin
      n_err++;
      $display("FAIL sv_exec got %0d exp 2", state);
    end
    wait_done(cyc);
    n_vec++;
    if (result !== {19'd8, 19'd8}) begin
      n_err++;
      $display("FAIL sv_result got %0d/%0d exp 8/8",
               result[37:19], result[18:0]);
    end
  endtask

  task automatic test_saturation();
    int an, rl, cyc;
    load_const(8'hff);
    pulse_start();
    feed(1'b0, an, rl);
    wait_done(cyc);
    n_vec++;
    if (result !== {19'd520200, 19'd520200}) begin
      n_err++;
      $display("FAIL wide_full got %0d/%0d exp 520200",
               result[37:19], result[18:0]);
    end
    n_vec++;
    if (done16 !== 1'b1) begin
      n_err++;
      $display("FAIL narrow_done got %b exp 1", done16);
    end
`ifdef MAC_ARRAY_SAT_EN
    n_vec++;
    if (r16 !== {16'd65535, 16'd65535}) begin
      n_err++;
      $display("FAIL narrow_sat got %0d/%0d exp 65535",
               r16[31:16], r16[15:0]);
    end
    n_vec++;
    if ({sat16, sat0} !== 2'b10) begin
      n_err++;
      $display("FAIL sat_flag got %b exp 10", {sat16, sat0});
    end
    pulse_start();
    n_vec++;
    if (sat16 !== 1'b0) begin
      n_err++;
      $display("FAIL sat_clear got %b exp 0", sat16);
    end
`else
    n_vec++;
    if (r16 !== {16'd61448, 16'd61448}) begin
      n_err++;
      $display("FAIL narrow_wrap got %0d/%0d exp 61448",
               r16[31:16], r16[15:0]);
    end
    pulse_start();
    n_vec++;
    if (r16 !== 32'd0) begin
      n_err++;
      $display("FAIL narrow_clear got %0h exp 0", r16);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_restart();
    test_reset_mid_exec();
    test_start_with_valid();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
